// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared definitions for the video DMA feeder: target encodings, MMIO register
// indices, target sizes, the transfer FSM state type and the destination
// offset wrap helper.
// -----------------------------------------------------------------------------
package video_pkg;

    // Destination target encodings (DST register bits [1:0]).
    localparam logic [1:0] TGT_TATTR   = 2'd0;
    localparam logic [1:0] TGT_TDATA   = 2'd1;
    localparam logic [1:0] TGT_PAL     = 2'd2;
    localparam logic [1:0] TGT_INVALID = 2'd3;

    // MMIO register indices.
    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    // Target sizes in target units (bytes, halfwords, palette entries).
    localparam int TATTR_SIZE = 512;
    localparam int TDATA_SIZE = 128;
    localparam int PAL_SIZE   = 16;

    // Width of the destination offset field (DST bits [17:8]).
    localparam int OFF_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VB = 2'd1,
        ST_FETCH   = 2'd2,
        ST_UNPACK  = 2'd3
    } dma_state_t;

    // Destination offset after one write, wrapped to the size of the target.
    function automatic logic [OFF_W-1:0] next_offset(input logic [1:0] tgt,
                                                     input logic [OFF_W-1:0] off);
        logic [OFF_W-1:0] inc;
        inc = off + OFF_W'(1);
        case (tgt)
            TGT_TATTR: return inc & OFF_W'(TATTR_SIZE - 1);
            TGT_TDATA: return inc & OFF_W'(TDATA_SIZE - 1);
            default:   return inc & OFF_W'(PAL_SIZE - 1);
        endcase
    endfunction

endpackage

// File: rtl/video_dma_unpack.sv
// -----------------------------------------------------------------------------
// video_dma_unpack
// Splits a latched 32-bit memory word into per-lane write data for the three
// video targets, little-endian lane order.
// Ports:
//   i_word  latched memory word
//   i_tgt   target encoding (tattr / tdata / palette)
//   i_lane  lane index within the word (0..3 for tattr, 0..1 otherwise)
//   o_byte  tile-attribute byte for this lane
//   o_half  tile-data halfword for this lane
//   o_pal   12-bit palette colour for this lane
//   o_last  this lane is the final one of the word for the given target
// -----------------------------------------------------------------------------
module video_dma_unpack
    import video_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_tgt,
    input  logic [1:0]  i_lane,
    output logic [7:0]  o_byte,
    output logic [15:0] o_half,
    output logic [11:0] o_pal,
    output logic        o_last
);

    logic [7:0] w_bytes [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign w_bytes[gi] = i_word[gi*8 +: 8];
        end
    endgenerate

    assign o_byte = w_bytes[i_lane];
    assign o_half = i_lane[0] ? i_word[31:16] : i_word[15:0];
    // Palette entries sit in the low 12 bits of each halfword.
    assign o_pal  = i_lane[0] ? i_word[27:16] : i_word[11:0];
    assign o_last = (i_tgt == TGT_TATTR) ? (i_lane == 2'd3) : i_lane[0];

endmodule

// File: rtl/video_dma.sv
// -----------------------------------------------------------------------------
// video_dma
// CPU-programmed copier from system memory into the tile video unit's
// tile-attribute RAM, tile-data RAM or palette. One word is fetched per
// memory handshake and unpacked one target write per cycle.
//
// Optional build macro: VIDEO_DMA_VBLANK_WAIT_EN
//   defined   - a valid start waits in WAIT_VB until vblank is high.
//   undefined - transfers begin immediately; vblank is ignored.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   cfg_addr/wdata/wenable/rdata    MMIO window (SRC, DST, LEN, CTRL)
//   vblank                          vertical blanking indicator
//   mem_req/addr/ack/rdata          memory read port (req held until ack)
//   tattr_addr/wdata/wenable        tile-attribute write port
//   tdata_addr/wdata/wenable        tile-data write port (byte enables)
//   pal_addr/wdata/wenable          palette write port
//   busy                            transfer in progress
// -----------------------------------------------------------------------------
module video_dma
    import video_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 10,
    parameter int TATTR_AW   = 9,
    parameter int TDATA_AW   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            cfg_addr,
    input  logic [31:0]           cfg_wdata,
    input  logic                  cfg_wenable,
    output logic [31:0]           cfg_rdata,
    input  logic                  vblank,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic [TATTR_AW-1:0]   tattr_addr,
    output logic [7:0]            tattr_wdata,
    output logic                  tattr_wenable,
    output logic [TDATA_AW-1:0]   tdata_addr,
    output logic [15:0]           tdata_wdata,
    output logic [1:0]            tdata_wenable,
    output logic [3:0]            pal_addr,
    output logic [11:0]           pal_wdata,
    output logic                  pal_wenable,
    output logic                  busy
);

    dma_state_t            r_state;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [1:0]            r_tgt;
    logic [OFF_W-1:0]      r_off;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [31:0]           r_word;
    logic [1:0]            r_lane;
    logic                  r_mem_req;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    logic                  w_start;
    logic                  w_cfg_ok;
    logic                  w_unpack;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [11:0]           w_pal;
    logic                  w_last;

`ifndef VIDEO_DMA_VBLANK_WAIT_EN
    // vblank has no function in this build.
    logic w_unused_vblank;
    assign w_unused_vblank = vblank;
`endif

    // Config registers are frozen while a transfer owns them.
    assign w_cfg_ok = cfg_wenable && (r_state == ST_IDLE);
    assign w_start  = w_cfg_ok && (cfg_addr == REG_CTRL) && cfg_wdata[0];
    assign w_unpack = (r_state == ST_UNPACK);

    video_dma_unpack u_unpack (
        .i_word (r_word),
        .i_tgt  (r_tgt),
        .i_lane (r_lane),
        .o_byte (w_byte),
        .o_half (w_half),
        .o_pal  (w_pal),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_src     <= '0;
            r_tgt     <= '0;
            r_off     <= '0;
            r_len     <= '0;
            r_word    <= '0;
            r_lane    <= '0;
            r_mem_req <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            if (w_cfg_ok) begin
                case (cfg_addr)
                    REG_SRC: r_src <= {cfg_wdata[ADDR_WIDTH-1:2], 2'b00};
                    REG_DST: begin
                        r_tgt <= cfg_wdata[1:0];
                        r_off <= cfg_wdata[17:8];
                    end
                    REG_LEN: r_len <= cfg_wdata[LEN_WIDTH-1:0];
                    default: ;
                endcase
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                        if (r_tgt == TGT_INVALID) begin
                            r_error <= 1'b1;
                            r_done  <= 1'b1;
                        end else if (r_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_busy <= 1'b1;
`ifdef VIDEO_DMA_VBLANK_WAIT_EN
                            r_state <= ST_WAIT_VB;
`else
                            r_state   <= ST_FETCH;
                            r_mem_req <= 1'b1;
`endif
                        end
                    end
                end

                ST_WAIT_VB: begin
                    if (vblank) begin
                        r_state   <= ST_FETCH;
                        r_mem_req <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    if (mem_ack) begin
                        r_word    <= mem_rdata;
                        r_src     <= r_src + ADDR_WIDTH'(4);
                        r_lane    <= 2'd0;
                        r_mem_req <= 1'b0;
                        r_state   <= ST_UNPACK;
                    end
                end

                ST_UNPACK: begin
                    r_off <= next_offset(r_tgt, r_off);
                    r_len <= r_len - LEN_WIDTH'(1);
                    if (r_len == LEN_WIDTH'(1)) begin
                        // Final unit written; any remaining lanes are dropped.
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_last) begin
                        r_state   <= ST_FETCH;
                        r_mem_req <= 1'b1;
                    end else begin
                        r_lane <= r_lane + 2'd1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            REG_SRC:  cfg_rdata = 32'(r_src);
            REG_DST:  cfg_rdata = {14'b0, r_off, 6'b0, r_tgt};
            REG_LEN:  cfg_rdata = 32'(r_len);
            default:  cfg_rdata = {29'b0, r_error, r_done, r_busy};
        endcase
    end

    assign mem_req  = r_mem_req;
    assign mem_addr = r_src;
    assign busy     = r_busy;

    assign tattr_addr    = r_off[TATTR_AW-1:0];
    assign tattr_wdata   = w_byte;
    assign tattr_wenable = w_unpack && (r_tgt == TGT_TATTR);

    assign tdata_addr    = {r_off[TDATA_AW-2:0], 1'b0};
    assign tdata_wdata   = w_half;
    assign tdata_wenable = {2{w_unpack && (r_tgt == TGT_TDATA)}};

    assign pal_addr    = r_off[3:0];
    assign pal_wdata   = w_pal;
    assign pal_wenable = w_unpack && (r_tgt == TGT_PAL);

endmodule

// File: tb/tb_video_dma.sv
// -----------------------------------------------------------------------------
// tb_video_dma
// Directed bench for video_dma: a simple memory responder with programmable
// ack delay, a write monitor logging every target write, and one task per
// scenario with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_video_dma;

    logic        clk;
    logic        rst;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_wenable;
    logic [31:0] cfg_rdata;
    logic        vblank;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [8:0]  tattr_addr;
    logic [7:0]  tattr_wdata;
    logic        tattr_wenable;
    logic [7:0]  tdata_addr;
    logic [15:0] tdata_wdata;
    logic [1:0]  tdata_wenable;
    logic [3:0]  pal_addr;
    logic [11:0] pal_wdata;
    logic        pal_wenable;
    logic        busy;

    video_dma dut (
        .clk(clk), .rst(rst),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_wenable(cfg_wenable),
        .cfg_rdata(cfg_rdata), .vblank(vblank),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .tattr_addr(tattr_addr), .tattr_wdata(tattr_wdata), .tattr_wenable(tattr_wenable),
        .tdata_addr(tdata_addr), .tdata_wdata(tdata_wdata), .tdata_wenable(tdata_wenable),
        .pal_addr(pal_addr), .pal_wdata(pal_wdata), .pal_wenable(pal_wenable),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int tgt;
        int addr;
        int data;
        int be;
    } wr_t;

    wr_t         wlog[$];
    logic [31:0] mem [1024];
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    int          hs        = 0;
    int          total     = 0;
    int          bad       = 0;

    // Memory responder: ack is a one-cycle pulse after ack_delay waiting cycles.
    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr[11:2]];
                wait_cnt  = 0;
                hs++;
            end else begin
                wait_cnt++;
            end
        end
    end

    // Write monitor.
    always @(negedge clk) begin
        if (tattr_wenable) begin
            wlog.push_back('{0, int'(tattr_addr), int'(tattr_wdata), 1});
            $display("wr tattr addr=%0h data=%0h", tattr_addr, tattr_wdata);
        end
        if (tdata_wenable != 2'b00) begin
            wlog.push_back('{1, int'(tdata_addr), int'(tdata_wdata), int'(tdata_wenable)});
            $display("wr tdata addr=%0h data=%0h be=%0b", tdata_addr, tdata_wdata, tdata_wenable);
        end
        if (pal_wenable) begin
            wlog.push_back('{2, int'(pal_addr), int'(pal_wdata), 1});
            $display("wr pal addr=%0h data=%0h", pal_addr, pal_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_addr    = a;
        cfg_wdata   = d;
        cfg_wenable = 1'b1;
        @(negedge clk);
        cfg_wenable = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic wait_done(input string name);
        logic [31:0] s;
        bit          seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            read_reg(2'd3, s);
            if (s[1]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_done: got done=0 after 300 cycles, want done=1", name);
        end
    endtask

    task automatic check_log(input string name, input int n,
                             input int et[], input int ea[], input int ed[]);
        total++;
        if (wlog.size() !== n) begin
            bad++;
            $display("FAIL %s_count: got %0d writes, want %0d", name, wlog.size(), n);
        end
        for (int i = 0; i < n && i < wlog.size(); i++) begin
            total++;
            if (wlog[i].tgt !== et[i] || wlog[i].addr !== ea[i] || wlog[i].data !== ed[i]) begin
                bad++;
                $display("FAIL %s_wr%0d: got tgt=%0d addr=%0h data=%0h, want tgt=%0d addr=%0h data=%0h",
                         name, i, wlog[i].tgt, wlog[i].addr, wlog[i].data, et[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({mem_req, busy, tattr_wenable, tdata_wenable, pal_wenable} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs: got req=%b busy=%b we=%b%b%b, want all 0",
                     mem_req, busy, tattr_wenable, tdata_wenable, pal_wenable);
        end
        for (int r = 0; r < 4; r++) begin
            read_reg(2'(r), d);
            total++;
            if (d !== 32'h0) begin
                bad++;
                $display("FAIL reset_reg%0d: got %0h, want 0", r, d);
            end
        end
    endtask

    task automatic test_tattr();
        logic [31:0] d;
        mem[64] = 32'h44332211;
        mem[65] = 32'h88776655;
        ack_delay = 0;
        hs = 0;
        wlog.delete();
        cfg_write(2'd0, 32'h0000_0100);
        cfg_write(2'd1, 32'h0000_0500);
        cfg_write(2'd2, 32'd6);
        cfg_write(2'd3, 32'd1);
`ifndef VIDEO_DMA_VBLANK_WAIT_EN
        total++;
        if (mem_req !== 1'b1 || busy !== 1'b1 || mem_addr !== 32'h100) begin
            bad++;
            $display("FAIL tattr_latency: got req=%b busy=%b addr=%0h, want req=1 busy=1 addr=100",
                     mem_req, busy, mem_addr);
        end
`endif
        wait_done("tattr");
        check_log("tattr", 6, '{0, 0, 0, 0, 0, 0}, '{5, 6, 7, 8, 9, 10},
                  '{'h11, 'h22, 'h33, 'h44, 'h55, 'h66});
        total++;
        if (hs !== 2) begin
            bad++;
            $display("FAIL tattr_handshakes: got %0d, want 2", hs);
        end
        read_reg(2'd3, d);
        total++;
        if (d !== 32'h2) begin
            bad++;
            $display("FAIL tattr_status: got %0h, want 2", d);
        end
        read_reg(2'd0, d);
        total++;
        if (d !== 32'h108) begin
            bad++;
            $display("FAIL tattr_src_end: got %0h, want 108", d);
        end
    endtask

    task automatic test_tdata();
        mem[128] = 32'hBEEFCAFE;
        ack_delay = 1;
        hs = 0;
        wlog.delete();
        cfg_write(2'd0, 32'h0000_0200);
        cfg_write(2'd1, (32'd127 << 8) | 32'd1);
        cfg_write(2'd2, 32'd2);
        cfg_write(2'd3, 32'd1);
        wait_done("tdata");
        check_log("tdata", 2, '{1, 1}, '{'hFE, 'h00}, '{'hCAFE, 'hBEEF});
        for (int i = 0; i < wlog.size(); i++) begin
            total++;
            if (wlog[i].be !== 3) begin
                bad++;
                $display("FAIL tdata_be%0d: got %0b, want 11", i, wlog[i].be);
            end
        end
    endtask

    task automatic test_palette();
        mem[192] = 32'h0ABC0123;
        mem[193] = 32'h00000FFF;
        ack_delay = 0;
        hs = 0;
        wlog.delete();
        cfg_write(2'd0, 32'h0000_0300);
        cfg_write(2'd1, (32'd15 << 8) | 32'd2);
        cfg_write(2'd2, 32'd3);
        cfg_write(2'd3, 32'd1);
        wait_done("pal");
        check_log("pal", 3, '{2, 2, 2}, '{15, 0, 1}, '{'h123, 'hABC, 'hFFF});
        total++;
        if (hs !== 2) begin
            bad++;
            $display("FAIL pal_handshakes: got %0d, want 2", hs);
        end
    endtask

    task automatic test_edge_cases();
        logic [31:0] d;
        hs = 0;
        wlog.delete();
        // Zero length: done one cycle after start, no memory traffic.
        cfg_write(2'd1, 32'h0000_0000);
        cfg_write(2'd2, 32'd0);
        cfg_write(2'd3, 32'd1);
        read_reg(2'd3, d);
        total++;
        if (d !== 32'h2 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL len0: got status=%0h req=%b, want status=2 req=0", d, mem_req);
        end
        repeat (3) @(negedge clk);
        total++;
        if (hs !== 0 || wlog.size() !== 0) begin
            bad++;
            $display("FAIL len0_quiet: got hs=%0d writes=%0d, want 0 and 0", hs, wlog.size());
        end
        // Invalid target.
        cfg_write(2'd1, 32'h0000_0003);
        cfg_write(2'd2, 32'd4);
        cfg_write(2'd3, 32'd1);
        read_reg(2'd3, d);
        total++;
        if (d !== 32'h6 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL invalid_tgt: got status=%0h req=%b, want status=6 req=0", d, mem_req);
        end
    endtask

    task automatic test_backpressure_busy();
        logic [31:0] d;
        mem[64] = 32'h44332211;
        ack_delay = 7;
        hs = 0;
        wlog.delete();
        cfg_write(2'd0, 32'h0000_0100);
        cfg_write(2'd1, 32'd20 << 8);
        cfg_write(2'd2, 32'd1);
        cfg_write(2'd3, 32'd1);
        // While waiting for the ack: SRC write and a second start are ignored.
        cfg_write(2'd0, 32'h0000_0500);
        cfg_write(2'd3, 32'd1);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h100 || wlog.size() !== 0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL bp_wait%0d: got req=%b addr=%0h writes=%0d busy=%b, want 1 100 0 1",
                         i, mem_req, mem_addr, wlog.size(), busy);
            end
            @(negedge clk);
        end
        wait_done("bp");
        check_log("bp", 1, '{0}, '{20}, '{'h11});
        read_reg(2'd0, d);
        total++;
        if (d !== 32'h104 || hs !== 1) begin
            bad++;
            $display("FAIL bp_src: got src=%0h hs=%0d, want src=104 hs=1", d, hs);
        end
        ack_delay = 0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bit          seen;
        int          n;
        mem[256] = 32'hA1B2C3D4;
        ack_delay = 0;
        wlog.delete();
        cfg_write(2'd0, 32'h0000_0400);
        cfg_write(2'd1, 32'h0000_0000);
        cfg_write(2'd2, 32'd4);
        cfg_write(2'd3, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (tattr_wenable) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rstmid_unpack: got no write within 30 cycles, want a write");
        end
        rst = 1'b1;
        @(negedge clk);
        read_reg(2'd3, d);
        total++;
        if ({mem_req, busy, tattr_wenable, tdata_wenable, pal_wenable} !== 5'b0 || d !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_quiet: got req=%b busy=%b we=%b%b%b status=%0h, want all 0",
                     mem_req, busy, tattr_wenable, tdata_wenable, pal_wenable, d);
        end
        rst = 1'b0;
        n = wlog.size();
        repeat (6) @(negedge clk);
        total++;
        if (wlog.size() !== n || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_after: got writes=%0d req=%b, want writes=%0d req=0",
                     wlog.size(), mem_req, n);
        end
    endtask

`ifdef VIDEO_DMA_VBLANK_WAIT_EN
    task automatic test_vblank();
        mem[64] = 32'h44332211;
        ack_delay = 0;
        wlog.delete();
        vblank = 1'b0;
        cfg_write(2'd0, 32'h0000_0100);
        cfg_write(2'd1, 32'h0000_0000);
        cfg_write(2'd2, 32'd1);
        cfg_write(2'd3, 32'd1);
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b1 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL vb_wait: got busy=%b req=%b, want busy=1 req=0", busy, mem_req);
        end
        vblank = 1'b1;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1) begin
            bad++;
            $display("FAIL vb_release: got req=%b, want 1", mem_req);
        end
        wait_done("vb");
        check_log("vb", 1, '{0}, '{0}, '{'h11});
    endtask
`endif

    initial begin
        rst         = 1'b1;
        cfg_addr    = 2'd0;
        cfg_wdata   = 32'h0;
        cfg_wenable = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;
`ifdef VIDEO_DMA_VBLANK_WAIT_EN
        vblank = 1'b1;
`else
        vblank = 1'b0;
`endif
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

        test_reset();
        test_tattr();
        test_tdata();
        test_palette();
        test_edge_cases();
        test_backpressure_busy();
        test_reset_mid();
`ifdef VIDEO_DMA_VBLANK_WAIT_EN
        test_vblank();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
